// File: rtl/gb_scanout.sv
// Frame-buffer scanout: VGA timing to fb addresses, palette lookup, aligned syncs.
// Centres the 2x-scaled 160x144 LCD image and owns the double-buffer bank swap.
module gb_scanout #(
    parameter int          X_OFF      = 160,
    parameter int          Y_OFF      = 96,
    parameter int          RDLAT      = 1,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       blank_in,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [7:0] fb_X_read,
    output logic [7:0] fb_Y_read,
    output logic       fb_bank,
    input  logic [1:0] fb_pixel,
    input  logic [7:0] palette,
    input  logic       frame_swap_req,
    output logic       frame_swap_ack,
    output logic       frame_start,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B
);

    localparam logic [9:0] XO = 10'(X_OFF);
    localparam logic [9:0] XE = 10'(X_OFF + 320);
    localparam logic [9:0] YO = 10'(Y_OFF);
    localparam logic [9:0] YE = 10'(Y_OFF + 288);

    logic       win;
    logic [9:0] dx;
    logic [9:0] dy;

    always_comb begin
        dx  = DrawX - XO;
        dy  = DrawY - YO;
        win = blank_in && (DrawX >= XO) && (DrawX < XE)
              && (DrawY >= YO) && (DrawY < YE);
    end

    // Stage A: halve the window offset to get the 2x-scaled source pixel
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_X_read <= '0;
            fb_Y_read <= '0;
        end else begin
            fb_X_read <= win ? dx[8:1] : 8'd0;
            fb_Y_read <= win ? dy[8:1] : 8'd0;
        end
    end

    logic [RDLAT:0] hs_p;
    logic [RDLAT:0] vs_p;
    logic [RDLAT:0] blank_p;
    logic [RDLAT:0] win_p;

    // Stage A+B: timing carried alongside the fb read latency
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_p    <= '1;
            vs_p    <= '1;
            blank_p <= '0;
            win_p   <= '0;
        end else begin
            hs_p    <= {hs_p[RDLAT-1:0], hs_in};
            vs_p    <= {vs_p[RDLAT-1:0], vs_in};
            blank_p <= {blank_p[RDLAT-1:0], blank_in};
            win_p   <= {win_p[RDLAT-1:0], win};
        end
    end

    logic [7:0]  palette_q;
    logic [1:0]  shade;
    logic [3:0]  nib;
    logic [11:0] rgb_n;

    // Shade 0..3 maps to F,A,5,0 which is the bit-inverse of {shade,shade}
    always_comb begin
        shade = palette_q[{fb_pixel, 1'b0} +: 2];
        nib   = ~{shade, shade};
        rgb_n = 12'h000;
        if (blank_p[RDLAT]) begin
            rgb_n = win_p[RDLAT] ? {nib, nib, nib} : BORDER_RGB;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
        end else begin
            VGA_HS <= hs_p[RDLAT];
            VGA_VS <= vs_p[RDLAT];
            VGA_R  <= rgb_n[11:8];
            VGA_G  <= rgb_n[7:4];
            VGA_B  <= rgb_n[3:0];
        end
    end

    logic fs_hit;
    logic fs_prev;
    logic fs_edge;

    always_comb begin
        fs_hit  = (DrawX == 10'd0) && (DrawY == 10'd0);
        fs_edge = fs_hit && !fs_prev;
    end

    // Palette and bank only change at the frame boundary to avoid tearing
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            fs_prev        <= 1'b0;
            frame_start    <= 1'b0;
            palette_q      <= 8'hE4;
            fb_bank        <= 1'b0;
            frame_swap_ack <= 1'b0;
        end else begin
            fs_prev     <= fs_hit;
            frame_start <= fs_edge;
            if (fs_edge) begin
                palette_q <= palette;
            end
            if (fs_edge && frame_swap_req && !frame_swap_ack) begin
                fb_bank        <= ~fb_bank;
                frame_swap_ack <= 1'b1;
            end else if (!frame_swap_req && frame_swap_ack) begin
                frame_swap_ack <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gb_scanout.sv
// Scoreboard bench for gb_scanout: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them.
module tb_gb_scanout;

    logic       Clk = 1'b0;
    logic       reset_n;
    logic       hs_in, vs_in, blank_in;
    logic [9:0] DrawX, DrawY;
    logic [7:0] fb_X_read, fb_Y_read;
    logic       fb_bank;
    logic [1:0] fb_pixel;
    logic [7:0] palette;
    logic       frame_swap_req, frame_swap_ack, frame_start;
    logic       VGA_HS, VGA_VS;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    always #5 Clk = ~Clk;

    gb_scanout #(.BORDER_RGB(12'h3C5)) dut (
        .Clk(Clk), .reset_n(reset_n),
        .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
        .DrawX(DrawX), .DrawY(DrawY),
        .fb_X_read(fb_X_read), .fb_Y_read(fb_Y_read),
        .fb_bank(fb_bank), .fb_pixel(fb_pixel), .palette(palette),
        .frame_swap_req(frame_swap_req), .frame_swap_ack(frame_swap_ack),
        .frame_start(frame_start),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    function automatic logic [1:0] fbpix(input logic [7:0] x, input logic [7:0] y);
        logic [9:0] s;
        s = 10'(x) + {1'b0, y, 1'b0} + 10'd3;
        return s[1:0];
    endfunction

    always @(posedge Clk) fb_pixel <= fbpix(fb_X_read, fb_Y_read);

    localparam int S_RGB = 0, S_FX = 1, S_FY = 2, S_BANK = 3;
    localparam int S_ACK = 4, S_FS = 5, S_HS = 6, S_VS = 7;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int got(input int s);
        case (s)
            S_RGB:   return int'({VGA_R, VGA_G, VGA_B});
            S_FX:    return int'(fb_X_read);
            S_FY:    return int'(fb_Y_read);
            S_BANK:  return int'(fb_bank);
            S_ACK:   return int'(frame_swap_ack);
            S_FS:    return int'(frame_start);
            S_HS:    return int'(VGA_HS);
            S_VS:    return int'(VGA_VS);
            default: return -1;
        endcase
    endfunction

    always @(negedge Clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                compared++;
                if (got(sb[i].sel) != sb[i].val) begin
                    mismatched++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h",
                             sb[i].name, cyc, got(sb[i].sel), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic px(input int x, input int y, input logic b,
                      input logic h, input logic v, output int c);
        @(posedge Clk);
        #1;
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        blank_in = b;
        hs_in    = h;
        vs_in    = v;
        c        = cyc;
    endtask

    task automatic ex(input int c, input int s, input int v, input string n);
        exp_t e;
        e.cyc  = c;
        e.sel  = s;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    int tx  [10] = '{160, 162, 164, 166, 300, 479, 480, 159, 200, 200};
    int ty  [10] = '{96, 96, 96, 100, 383, 200, 200, 100, 95, 384};
    int tfx [10] = '{0, 1, 2, 3, 70, 159, 0, 0, 0, 0};
    int tfy [10] = '{0, 0, 0, 2, 143, 52, 0, 0, 0, 0};
    int trgb[10] = '{'h000, 'hFFF, 'hAAA, 'h555, 'h000, 'h555,
                     'h3C5, 'h3C5, 'h3C5, 'h3C5};

    initial begin
        #100000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        reset_n        = 1'b0;
        DrawX          = 10'd5;
        DrawY          = 10'd5;
        blank_in       = 1'b0;
        hs_in          = 1'b1;
        vs_in          = 1'b1;
        palette        = 8'hE4;
        frame_swap_req = 1'b0;

        px(5, 5, 0, 1, 1, c);
        compared++;
        if (fb_bank !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_now_bank: got %0h expected 0", fb_bank);
        end
        compared++;
        if (frame_swap_ack !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_now_ack: got %0h expected 0", frame_swap_ack);
        end
        compared++;
        if (VGA_HS !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_now_hs: got %0h expected 1", VGA_HS);
        end
        compared++;
        if (VGA_VS !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_now_vs: got %0h expected 1", VGA_VS);
        end
        compared++;
        if (frame_start !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_now_fs: got %0h expected 0", frame_start);
        end
        compared++;
        if ({fb_X_read, fb_Y_read} !== 16'h0000) begin
            mismatched++;
            $display("FAIL rst_now_fxy: got %0h expected 0",
                     {fb_X_read, fb_Y_read});
        end
        compared++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
            mismatched++;
            $display("FAIL rst_now_rgb: got %0h expected 0",
                     {VGA_R, VGA_G, VGA_B});
        end
        ex(c, S_RGB, 0, "rst_rgb");
        ex(c, S_FX, 0, "rst_fx");
        ex(c, S_FY, 0, "rst_fy");
        ex(c, S_BANK, 0, "rst_bank");
        ex(c, S_ACK, 0, "rst_ack");
        ex(c, S_FS, 0, "rst_fs");
        ex(c, S_HS, 1, "rst_hs");
        ex(c, S_VS, 1, "rst_vs");
        px(5, 5, 0, 1, 1, c);
        reset_n = 1'b1;

        px(0, 0, 0, 1, 1, c);
        ex(c + 1, S_FS, 1, "fs_first");
        px(0, 0, 0, 1, 1, c);
        ex(c + 1, S_FS, 0, "fs_once");
        ex(c + 1, S_BANK, 0, "bank_noreq");

        for (int i = 0; i < 10; i++) begin
            px(tx[i], ty[i], 1, 1, 1, c);
            ex(c + 1, S_FX, tfx[i], $sformatf("fx_%0d_%0d", tx[i], ty[i]));
            ex(c + 1, S_FY, tfy[i], $sformatf("fy_%0d_%0d", tx[i], ty[i]));
            ex(c + 3, S_RGB, trgb[i], $sformatf("rgb_%0d_%0d", tx[i], ty[i]));
        end

        px(200, 100, 0, 1, 1, c);
        ex(c + 1, S_FX, 0, "blank_fx");
        ex(c + 3, S_RGB, 0, "blank_rgb");

        px(200, 100, 1, 0, 1, c);
        ex(c + 2, S_HS, 1, "hs_early");
        ex(c + 3, S_HS, 0, "hs_delay");
        px(200, 100, 1, 1, 0, c);
        ex(c + 3, S_HS, 1, "hs_back");
        ex(c + 2, S_VS, 1, "vs_early");
        ex(c + 3, S_VS, 0, "vs_delay");
        px(200, 100, 1, 1, 1, c);
        ex(c + 3, S_VS, 1, "vs_back");

        palette        = 8'h1B;
        frame_swap_req = 1'b1;
        px(162, 96, 1, 1, 1, c);
        ex(c + 3, S_RGB, 'hFFF, "pal_hold");
        ex(c + 1, S_BANK, 0, "bank_wait");
        ex(c + 1, S_ACK, 0, "ack_wait");
        px(5, 5, 0, 1, 1, c);
        px(5, 5, 0, 1, 1, c);

        px(0, 0, 0, 1, 1, c);
        ex(c + 1, S_FS, 1, "fs_swap");
        ex(c + 1, S_BANK, 1, "bank_swap");
        ex(c + 1, S_ACK, 1, "ack_swap");
        px(0, 0, 0, 1, 1, c);
        px(162, 96, 1, 1, 1, c);
        ex(c + 3, S_RGB, 'h000, "pal_new_idx0");
        px(160, 96, 1, 1, 1, c);
        ex(c + 3, S_RGB, 'hFFF, "pal_new_idx3");
        px(5, 5, 0, 1, 1, c);

        px(0, 0, 0, 1, 1, c);
        ex(c + 1, S_FS, 1, "fs_held");
        ex(c + 1, S_BANK, 1, "bank_one_toggle");
        ex(c + 1, S_ACK, 1, "ack_held");
        px(5, 5, 0, 1, 1, c);
        frame_swap_req = 1'b0;
        ex(c, S_ACK, 1, "ack_before_drop");
        ex(c + 1, S_ACK, 0, "ack_drop");

        px(5, 5, 0, 1, 1, c);
        frame_swap_req = 1'b1;
        px(5, 5, 0, 1, 1, c);
        ex(c + 1, S_ACK, 0, "ack_midframe");
        frame_swap_req = 1'b0;
        px(5, 5, 0, 1, 1, c);
        px(0, 0, 0, 1, 1, c);
        ex(c + 1, S_FS, 1, "fs_noswap");
        ex(c + 1, S_BANK, 1, "bank_withdrawn");
        ex(c + 1, S_ACK, 0, "ack_withdrawn");
        px(5, 5, 0, 1, 1, c);

        for (int i = 0; i < 4; i++) px(166, 100, 1, 1, 1, c);
        #2;
        reset_n = 1'b0;
        ex(c, S_FX, 0, "midrst_fx");
        ex(c, S_FY, 0, "midrst_fy");
        ex(c, S_RGB, 0, "midrst_rgb");
        ex(c, S_BANK, 0, "midrst_bank");
        ex(c, S_HS, 1, "midrst_hs");
        px(5, 5, 0, 1, 1, c);
        reset_n = 1'b1;
        px(166, 100, 1, 1, 1, c);
        ex(c + 1, S_FX, 3, "resume_fx");
        ex(c + 3, S_RGB, 'h555, "resume_rgb");
        px(5, 5, 0, 1, 1, c);

        repeat (6) @(posedge Clk);
        @(negedge Clk);
        #1;
        foreach (sb[i]) begin
            compared++;
            mismatched++;
            $display("FAIL %s: got never-checked expected check at cyc %0d",
                     sb[i].name, sb[i].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
